dma_mem_cpu_oci_trace_capture: RTL and testbench
================================================

# dma_mem_cpu_oci_trace_capture

Parametrised on-chip trace capture buffer for the Nios II OCI debug path in the DMA memory subsystem. It accepts compressed debug trace words (`dct_buffer`) and stores them in a circular buffer of configurable depth, in stop-when-full or overwrite-oldest mode. It freezes capture at test end and drains the captured words over a valid/ready read port. It generalises the fixed 30-bit, single-word trace monitor to arbitrary width and depth, and adds occupancy, overflow accounting and end-of-test sequencing.

## Interface
Parameters:
- `DCT_W`, 30: trace word width.
- `ADDR_W`, 4: buffer address width; `DEPTH` = 2**`ADDR_W` entries.
- `DROP_W`, 16: dropped-word counter width.

Ports:
- `clk`  in  1  single clock; all logic rises on `clk`.
- `reset`  in  1  synchronous, active-high reset.
- `dct_valid`  in  1  trace word present this cycle.
- `dct_buffer`  in  `DCT_W`  trace word.
- `wrap_mode`  in  1  0 = stop when full (drop new words); 1 = overwrite oldest. Sampled every cycle; held static during capture.
- `test_ending`  in  1  freeze request; level or pulse.
- `test_has_ended`  in  1  end-of-test indication; enables DONE.
- `rd_valid`  out  1  buffer non-empty.
- `rd_data`  out  `DCT_W`  oldest stored word.
- `rd_ready`  in  1  consumer accepts `rd_data`.
- `dct_count`  out  `ADDR_W`+1  occupancy, 0..`DEPTH`.
- `overflow`  out  1  sticky; at least one word was dropped or overwritten.
- `dropped_cnt`  out  `DROP_W`  count of dropped or overwritten words; saturates at all-ones.
- `frozen`  out  1  high in FROZEN and DONE.
- `done`  out  1  high in DONE.

## Operation
- Storage: register array of `DEPTH` x `DCT_W`, with `wr_ptr` and `rd_ptr` (`ADDR_W` bits each, natural wrap at `DEPTH`-1 -> 0) plus `dct_count`.
- A write occurs when `dct_valid`=1 and the state is CAPTURE. A pop occurs when `rd_valid`=1 and `rd_ready`=1, in any state.
- State machine:
  - CAPTURE: entered at reset; goes to FROZEN when `test_ending`=1.
  - FROZEN: goes to DONE when `test_has_ended`=1 and `dct_count`=0 (a pop this cycle that empties the buffer counts as 0).
  - DONE: terminal; only `reset` leaves it.
- Writes are ignored in FROZEN and DONE, and are not counted as drops.
- Count update rules:
  - Write only, not full: store at `wr_ptr`, increment `wr_ptr` and count.
  - Pop only: increment `rd_ptr`, decrement count.
  - Write and pop together, count > 0: both pointers advance and the count is unchanged. This includes full; no overflow.
  - Write and pop together, count = 0: impossible, because `rd_valid`=0.
  - Write, full, no pop, `wrap_mode`=0: word discarded, `overflow` set, `dropped_cnt` incremented.
  - Write, full, no pop, `wrap_mode`=1: store at `wr_ptr`, advance both pointers, count stays `DEPTH`, `overflow` set, `dropped_cnt` incremented.
- `rd_valid` = (`dct_count` != 0). `rd_data` = mem[`rd_ptr`], driven combinationally from registers.
- `dropped_cnt` saturates at 2**`DROP_W`-1. `overflow` stays set.

## Timing
- Reset values: `rd_valid`=0, `dct_count`=0, `overflow`=0, `dropped_cnt`=0, `frozen`=0, `done`=0, pointers=0, state CAPTURE. Memory contents are not reset; `rd_data` is don't-care while `rd_valid`=0.
- A word written at edge N is visible on `rd_data`/`rd_valid` from edge N (cycle N+1). Write-to-read latency is 1 cycle.
- The consumer must not depend on `rd_data` changing without a pop, except in wrap mode while full, where an overwrite advances `rd_ptr`.
- `test_ending` and `dct_valid` in the same cycle: the word is captured, and `frozen`=1 from the next cycle.
- `test_has_ended` before `test_ending`: no effect. DONE requires passing through FROZEN, so the earliest DONE is 1 cycle after FROZEN is entered.
- `reset` asserted mid-capture or mid-drain: all state returns to reset values at the next edge, and any in-flight pop is lost.
- `reset` has priority over every other input.

## Test plan
- Fill 5 words (0x1..0x5) with `DEPTH`=16, then drain with `rd_ready`=1 -> `rd_data` is 0x1..0x5 in order; `dct_count` goes 5->0; `overflow`=0.
- Stop mode: write 20 words (0x00..0x13) with no reads -> `dct_count`=16, `overflow`=1, `dropped_cnt`=4; drain yields 0x00..0x0F.
- Wrap mode: same 20 words -> `dct_count`=16, `dropped_cnt`=4; drain yields 0x04..0x13.
- Full buffer with simultaneous write 0xAA and pop, in both modes -> `dct_count` stays 16, `dropped_cnt` unchanged, 0xAA is the last word drained.
- Pulse `test_ending` with `dct_valid` (word 0x7); further writes follow; then `test_has_ended`=1 and drain -> 0x7 is the last stored word, later writes are ignored, and `done`=1 on the cycle after the final pop.
- Assert `reset` while `dct_count`=9 and `frozen`=1 -> next cycle all outputs are at reset values, and a fresh write is readable 1 cycle later.

Source files
------------

// File: rtl/dma_mem_cpu_oci_trace_capture.sv
// Circular capture buffer for compressed OCI debug trace words, with freeze-on-test-end
// and a valid/ready drain port. Stop-when-full or overwrite-oldest selectable by wrap_mode.
module dma_mem_cpu_oci_trace_capture #(
   parameter int unsigned DCT_W  = 30,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DROP_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dct_valid,
   input  logic [DCT_W-1:0]  dct_buffer,
   input  logic              wrap_mode,
   input  logic              test_ending,
   input  logic              test_has_ended,
   output logic              rd_valid,
   output logic [DCT_W-1:0]  rd_data,
   input  logic              rd_ready,
   output logic [ADDR_W:0]   dct_count,
   output logic              overflow,
   output logic [DROP_W-1:0] dropped_cnt,
   output logic              frozen,
   output logic              done
);

   localparam int unsigned Depth = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(Depth);

   typedef enum logic [1:0] {StCapture, StFrozen, StDone} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                overflow_q, overflow_d;
   logic [DROP_W-1:0]   dropped_q, dropped_d;
   logic [DCT_W-1:0]    mem_q [Depth];

   logic wr_req, pop, full, do_write, drop, overwrite, grow;

   always_comb begin
      wr_req    = dct_valid && (state_q == StCapture);
      pop       = (count_q != '0) && rd_ready;
      full      = (count_q == FullCnt);
      drop      = wr_req && full && !pop;
      // In wrap mode a write to a full buffer evicts the oldest word instead of being discarded.
      overwrite = drop && wrap_mode;
      do_write  = wr_req && (!full || pop || wrap_mode);
      grow      = do_write && !overwrite;

      wr_ptr_d   = do_write ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = (pop || overwrite) ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d    = count_q + {{ADDR_W{1'b0}}, grow} - {{ADDR_W{1'b0}}, pop};
      overflow_d = overflow_q || drop;
      dropped_d  = (drop && (dropped_q != '1)) ? dropped_q + 1'b1 : dropped_q;

      state_d = state_q;
      unique case (state_q)
         StCapture: if (test_ending) state_d = StFrozen;
         StFrozen:  if (test_has_ended && (count_d == '0)) state_d = StDone;
         StDone:    state_d = StDone;
         default:   state_d = StCapture;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StCapture;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         dropped_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         dropped_q  <= dropped_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && do_write) mem_q[wr_ptr_q] <= dct_buffer;
   end

   assign rd_valid    = (count_q != '0);
   assign rd_data     = mem_q[rd_ptr_q];
   assign dct_count   = count_q;
   assign overflow    = overflow_q;
   assign dropped_cnt = dropped_q;
   assign frozen      = (state_q != StCapture);
   assign done        = (state_q == StDone);

endmodule

// File: tb/tb_dma_mem_cpu_oci_trace_capture.sv
// Directed bench for the trace capture buffer: fill/drain, stop and wrap overflow,
// full write+pop, freeze/done sequencing and mid-run reset.
module tb_dma_mem_cpu_oci_trace_capture;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        dct_valid = 1'b0;
   logic [29:0] dct_buffer = '0;
   logic        wrap_mode = 1'b0;
   logic        test_ending = 1'b0;
   logic        test_has_ended = 1'b0;
   logic        rd_valid;
   logic [29:0] rd_data;
   logic        rd_ready = 1'b0;
   logic [4:0]  dct_count;
   logic        overflow;
   logic [15:0] dropped_cnt;
   logic        frozen;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   dma_mem_cpu_oci_trace_capture #(
      .DCT_W (30),
      .ADDR_W(4),
      .DROP_W(16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .dct_valid     (dct_valid),
      .dct_buffer    (dct_buffer),
      .wrap_mode     (wrap_mode),
      .test_ending   (test_ending),
      .test_has_ended(test_has_ended),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .rd_ready      (rd_ready),
      .dct_count     (dct_count),
      .overflow      (overflow),
      .dropped_cnt   (dropped_cnt),
      .frozen        (frozen),
      .done          (done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
      check_eq({tag, "_count"}, 64'(dct_count), 64'd0);
      check_eq({tag, "_overflow"}, 64'(overflow), 64'd0);
      check_eq({tag, "_dropped"}, 64'(dropped_cnt), 64'd0);
      check_eq({tag, "_frozen"}, 64'(frozen), 64'd0);
      check_eq({tag, "_done"}, 64'(done), 64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      dct_valid = 1'b0;
      rd_ready = 1'b0;
      test_ending = 1'b0;
      test_has_ended = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic push_seq(input logic [29:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         dct_valid  = 1'b1;
         dct_buffer = base + 30'(i);
         tick();
      end
      dct_valid = 1'b0;
   endtask

   task automatic drain_seq(input string tag, input logic [29:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         check_eq({tag, "_valid"}, 64'(rd_valid), 64'd1);
         check_eq({tag, "_data"}, 64'(rd_data), 64'(base + 30'(i)));
         rd_ready = 1'b1;
         tick();
         rd_ready = 1'b0;
      end
   endtask

   initial begin
      // Reset state
      tick();
      reset = 1'b0;
      check_reset_state("rst");

      // Fill 5, drain in order
      push_seq(30'h1, 1);
      check_eq("lat_valid", 64'(rd_valid), 64'd1);
      check_eq("lat_data", 64'(rd_data), 64'h1);
      push_seq(30'h2, 4);
      check_eq("fill5_count", 64'(dct_count), 64'd5);
      for (int i = 0; i < 5; i++) begin
         check_eq("fill5_cnt_step", 64'(dct_count), 64'(5 - i));
         check_eq("fill5_data", 64'(rd_data), 64'(i + 1));
         rd_ready = 1'b1;
         tick();
         rd_ready = 1'b0;
      end
      check_eq("fill5_empty", 64'(dct_count), 64'd0);
      check_eq("fill5_rd_valid", 64'(rd_valid), 64'd0);
      check_eq("fill5_overflow", 64'(overflow), 64'd0);

      // Stop mode overflow
      do_reset();
      wrap_mode = 1'b0;
      push_seq(30'h0, 20);
      check_eq("stop_count", 64'(dct_count), 64'd16);
      check_eq("stop_overflow", 64'(overflow), 64'd1);
      check_eq("stop_dropped", 64'(dropped_cnt), 64'd4);
      drain_seq("stop_drain", 30'h0, 16);
      check_eq("stop_empty", 64'(rd_valid), 64'd0);
      check_eq("stop_overflow_sticky", 64'(overflow), 64'd1);

      // Wrap mode overflow
      do_reset();
      wrap_mode = 1'b1;
      push_seq(30'h0, 20);
      check_eq("wrap_count", 64'(dct_count), 64'd16);
      check_eq("wrap_overflow", 64'(overflow), 64'd1);
      check_eq("wrap_dropped", 64'(dropped_cnt), 64'd4);
      drain_seq("wrap_drain", 30'h4, 16);
      check_eq("wrap_empty", 64'(dct_count), 64'd0);

      // Full buffer, write and pop in the same cycle, both modes
      for (int m = 0; m < 2; m++) begin
         do_reset();
         wrap_mode = m[0];
         push_seq(30'h100, 16);
         dct_valid  = 1'b1;
         dct_buffer = 30'hAA;
         rd_ready   = 1'b1;
         tick();
         dct_valid = 1'b0;
         rd_ready  = 1'b0;
         check_eq("full_wp_count", 64'(dct_count), 64'd16);
         check_eq("full_wp_dropped", 64'(dropped_cnt), 64'd0);
         check_eq("full_wp_overflow", 64'(overflow), 64'd0);
         drain_seq("full_wp_drain", 30'h101, 15);
         check_eq("full_wp_last", 64'(rd_data), 64'hAA);
         check_eq("full_wp_last_cnt", 64'(dct_count), 64'd1);
         rd_ready = 1'b1;
         tick();
         rd_ready = 1'b0;
         check_eq("full_wp_empty", 64'(dct_count), 64'd0);
      end

      // Freeze and done sequencing
      do_reset();
      wrap_mode = 1'b0;
      test_has_ended = 1'b1;
      tick();
      test_has_ended = 1'b0;
      check_eq("early_end_frozen", 64'(frozen), 64'd0);
      check_eq("early_end_done", 64'(done), 64'd0);
      push_seq(30'h5, 2);
      dct_valid   = 1'b1;
      dct_buffer  = 30'h7;
      test_ending = 1'b1;
      tick();
      test_ending = 1'b0;
      dct_valid   = 1'b0;
      check_eq("frz_frozen", 64'(frozen), 64'd1);
      check_eq("frz_count", 64'(dct_count), 64'd3);
      push_seq(30'h8, 2);
      check_eq("frz_ignored_count", 64'(dct_count), 64'd3);
      check_eq("frz_ignored_dropped", 64'(dropped_cnt), 64'd0);
      check_eq("frz_ignored_overflow", 64'(overflow), 64'd0);
      test_has_ended = 1'b1;
      tick();
      check_eq("frz_not_done", 64'(done), 64'd0);
      drain_seq("frz_drain", 30'h5, 2);
      check_eq("frz_pre_done", 64'(done), 64'd0);
      check_eq("frz_last_word", 64'(rd_data), 64'h7);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      check_eq("frz_done", 64'(done), 64'd1);
      check_eq("frz_done_frozen", 64'(frozen), 64'd1);
      check_eq("frz_done_empty", 64'(rd_valid), 64'd0);
      test_has_ended = 1'b0;
      tick();
      check_eq("frz_done_sticky", 64'(done), 64'd1);

      // Reset mid-drain while frozen with 9 words held
      do_reset();
      push_seq(30'h20, 9);
      test_ending = 1'b1;
      tick();
      test_ending = 1'b0;
      check_eq("mid_frozen", 64'(frozen), 64'd1);
      check_eq("mid_count", 64'(dct_count), 64'd9);
      reset    = 1'b1;
      rd_ready = 1'b1;
      tick();
      reset    = 1'b0;
      rd_ready = 1'b0;
      check_reset_state("mid_rst");
      push_seq(30'h55, 1);
      check_eq("mid_fresh_valid", 64'(rd_valid), 64'd1);
      check_eq("mid_fresh_data", 64'(rd_data), 64'h55);
      check_eq("mid_fresh_count", 64'(dct_count), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
